// File: rtl/rsa_modexp_mont_if.sv
// ---------------------------------------------------------------------------
// rsa_modexp_mont_if
// Operand/result bundle between the RSA enable controller / SPI register
// bank side (master) and the modular-exponentiation engine (slave).
//   en     : run enable (controller en_rsa)
//   P      : modulus, odd and > 1
//   E      : exponent
//   M      : message, < P
//   Const  : R^2 mod P, R = 2^WIDTH
//   eoc    : end of conversion, C valid while high
//   C      : result M^E mod P
//   err    : operand error flag
//   busy   : computation in progress
// ---------------------------------------------------------------------------
interface rsa_modexp_mont_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [WIDTH-1:0] P;
    logic [WIDTH-1:0] E;
    logic [WIDTH-1:0] M;
    logic [WIDTH-1:0] Const;
    logic             eoc;
    logic [WIDTH-1:0] C;
    logic             err;
    logic             busy;

    modport master (
        output en, P, E, M, Const,
        input  eoc, C, err, busy
    );

    modport slave (
        input  en, P, E, M, Const,
        output eoc, C, err, busy
    );
endinterface

// File: rtl/rsa_modexp_mont.sv
// ---------------------------------------------------------------------------
// rsa_modexp_mont
// Computes C = M^E mod P by left-to-right square-and-multiply over bit-serial
// radix-2 Montgomery multiplications (R = 2^WIDTH). Every Montgomery product
// takes WIDTH step cycles plus one final conditional-subtract cycle.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset (priority over en)
//   bus  : slave side of rsa_modexp_mont_if (en, P, E, M, Const in;
//          eoc, C, err, busy out, all outputs registered)
// ---------------------------------------------------------------------------
module rsa_modexp_mont #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    rsa_modexp_mont_if.slave  bus
);
    localparam int TW = WIDTH + 2;
    localparam int CW = $clog2(WIDTH + 1);
    localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [CW-1:0]    CYC_LAST = CW'(WIDTH);
    localparam logic [KW-1:0]    K_TOP    = KW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        PRE_M,
        PRE_X,
        SQR,
        MUL,
        POST,
        DONE
    } state_t;

    state_t           state,   state_n;
    logic [WIDTH-1:0] p_r,     p_n;
    logic [WIDTH-1:0] e_r,     e_n;
    logic [WIDTH-1:0] m_r,     m_n;
    logic [WIDTH-1:0] const_r, const_n;
    logic [WIDTH-1:0] mb_r,    mb_n;
    logic [WIDTH-1:0] x_r,     x_n;
    logic [TW-1:0]    t_r,     t_n;
    logic [CW-1:0]    cyc,     cyc_n;
    logic [KW-1:0]    k,       k_n;
    logic [WIDTH-1:0] c_r,     c_n;
    logic             eoc_r,   eoc_n;
    logic             err_r,   err_n;
    logic             busy_r,  busy_n;

    // Montgomery datapath
    logic [WIDTH-1:0] op_a, op_b;
    logic             a_bit, e_bit, last, op_err, t_ge_p;
    logic [TW-1:0]    p_ext, sum, step_res;
    logic [WIDTH-1:0] result;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all flops update together
        // from values computed in the previous cycle.
        if (rst) begin
            state   <= IDLE;
            p_r     <= '0;
            e_r     <= '0;
            m_r     <= '0;
            const_r <= '0;
            mb_r    <= '0;
            x_r     <= '0;
            t_r     <= '0;
            cyc     <= '0;
            k       <= '0;
            c_r     <= '0;
            eoc_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_n;
            p_r     <= p_n;
            e_r     <= e_n;
            m_r     <= m_n;
            const_r <= const_n;
            mb_r    <= mb_n;
            x_r     <= x_n;
            t_r     <= t_n;
            cyc     <= cyc_n;
            k       <= k_n;
            c_r     <= c_n;
            eoc_r   <= eoc_n;
            err_r   <= err_n;
            busy_r  <= busy_n;
        end
    end

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case statements can leave one unassigned (no latches).
        state_n = state;
        p_n     = p_r;
        e_n     = e_r;
        m_n     = m_r;
        const_n = const_r;
        mb_n    = mb_r;
        x_n     = x_r;
        t_n     = t_r;
        cyc_n   = cyc;
        k_n     = k;
        c_n     = c_r;
        eoc_n   = eoc_r;
        err_n   = err_r;
        busy_n  = busy_r;

        // Operand selection for the Montgomery product of the current state.
        op_a = '0;
        op_b = '0;
        case (state)
            PRE_M: begin op_a = m_r; op_b = const_r; end
            PRE_X: begin op_a = ONE; op_b = const_r; end
            SQR:   begin op_a = x_r; op_b = x_r;     end
            MUL:   begin op_a = x_r; op_b = mb_r;    end
            POST:  begin op_a = x_r; op_b = ONE;     end
            default: ;
        endcase

        // One radix-2 step: add a[i]*b, make even by adding P, halve.
        // ONE << cyc is zero on the reduce cycle, where a_bit is unused anyway.
        a_bit = |(op_a & (ONE << cyc));
        p_ext = {2'b00, p_r};
        sum   = t_r + (a_bit ? {2'b00, op_b} : '0);
        if (sum[0]) begin
            sum = sum + p_ext;
        end
        step_res = {1'b0, sum[TW-1:1]};

        // Final reduction: T < 2P, so one conditional subtract suffices and
        // the result fits in WIDTH bits, making modulo-2^WIDTH arithmetic exact.
        t_ge_p = (t_r >= p_ext);
        result = t_ge_p ? (t_r[WIDTH-1:0] - p_r) : t_r[WIDTH-1:0];

        last   = (cyc == CYC_LAST);
        e_bit  = |(e_r & (ONE << k));
        op_err = ~p_r[0] | (p_r <= ONE) | (m_r >= p_r);

        if (bus.en) begin
            case (state)
                IDLE: begin
                    p_n     = bus.P;
                    e_n     = bus.E;
                    m_n     = bus.M;
                    const_n = bus.Const;
                    busy_n  = 1'b1;
                    t_n     = '0;
                    cyc_n   = '0;
                    k_n     = K_TOP;
                    state_n = PRE_M;
                end

                PRE_M, PRE_X, SQR, MUL, POST: begin
                    // Operands are validated on the first cycle after the latch
                    // so the error response appears one cycle after latching
                    // without adding a cycle to the normal path.
                    if (state == PRE_M && cyc == '0 && op_err) begin
                        state_n = DONE;
                        err_n   = 1'b1;
                        eoc_n   = 1'b1;
                        busy_n  = 1'b0;
                        c_n     = '0;
                    end else if (!last) begin
                        t_n   = step_res;
                        cyc_n = cyc + 1'b1;
                    end else begin
                        t_n   = '0;
                        cyc_n = '0;
                        case (state)
                            PRE_M: begin
                                mb_n    = result;
                                state_n = PRE_X;
                            end
                            PRE_X: begin
                                x_n     = result;
                                state_n = SQR;
                            end
                            SQR: begin
                                x_n = result;
                                if (e_bit) begin
                                    state_n = MUL;
                                end else if (k == '0) begin
                                    state_n = POST;
                                end else begin
                                    k_n     = k - 1'b1;
                                    state_n = SQR;
                                end
                            end
                            MUL: begin
                                x_n = result;
                                if (k == '0) begin
                                    state_n = POST;
                                end else begin
                                    k_n     = k - 1'b1;
                                    state_n = SQR;
                                end
                            end
                            default: begin
                                // POST: leave the Montgomery domain.
                                c_n     = result;
                                eoc_n   = 1'b1;
                                busy_n  = 1'b0;
                                state_n = DONE;
                            end
                        endcase
                    end
                end

                default: ; // DONE holds until rst
            endcase
        end
    end

    assign bus.eoc  = eoc_r;
    assign bus.C    = c_r;
    assign bus.err  = err_r;
    assign bus.busy = busy_r;

endmodule

// File: doc/rsa_modexp_mont.md
Name: rsa_modexp_mont

Overview:
- Modular-exponentiation engine computing C = M^E mod P with bit-serial radix-2 Montgomery multiplication.
- Sits directly downstream of the RSA enable controller. `en` is driven by the controller's `en_rsa`, `rst` by its `rst_rsa`, and `eoc` is returned as `eoc_rsa_unit`.
- P, E, M and Const come from the SPI register bank. C is written back to the register bank when eoc is high.

Parameters:
- WIDTH, 8, operand width in bits. Montgomery radix is R = 2^WIDTH.

Ports:
- clk    in   1      system clock
- rst    in   1      synchronous, active-high reset
- en     in   1      run enable: starts a computation from IDLE; holds all state when low
- P      in   WIDTH  modulus; must be odd and > 1
- E      in   WIDTH  exponent
- M      in   WIDTH  message; must be < P
- Const  in   WIDTH  R^2 mod P, precomputed by software
- eoc    out  1      end of conversion; C is valid while eoc is high
- C      out  WIDTH  result
- err    out  1      operand error flag
- busy   out  1      computation in progress

Behaviour:
- Clocking/reset:
  - Single clock domain. All outputs are registered.
  - Reset is synchronous and active-high: state=IDLE, eoc=0, err=0, busy=0, C=0, all internal registers 0.
  - rst has priority over en in the same cycle.
  - Asserting rst mid-operation aborts the computation; outputs return to reset values on the next edge.
- en gating:
  - When en=0 every register holds its value, including state, bit counters and accumulators. Cycles spent with en=0 add latency only.
- IDLE:
  - On a clock edge with en=1: latch P, E, M, Const into internal registers; set busy=1.
  - If latched P[0]=0, or P<=1, or M>=P: next state DONE, err=1, C=0, busy=0.
  - Otherwise: next state PRE_M.
  - Input port changes after this latch edge have no effect.
- MMM(a,b) primitive:
  - Accumulator T is WIDTH+2 bits, initialised to 0.
  - Step cycles i = 0..WIDTH-1: T = T + (a[i] ? b : 0); if T is odd, T = T + P; then T = T >> 1.
  - Cycle WIDTH (reduce): if T >= P, T = T - P.
  - Each MMM occupies exactly WIDTH+1 cycles. The result is < P.
- State sequence (each MMM state lasts WIDTH+1 cycles):
  - PRE_M: Mb = MMM(M, Const).
  - PRE_X: X = MMM(1, Const), which equals R mod P.
  - SQR: X = MMM(X, X). Then, if E[k]=1 go to MUL, else go to the next bit.
  - MUL: X = MMM(X, Mb).
  - Bit index k runs from WIDTH-1 down to 0. There is no leading-zero skip: all WIDTH bits are scanned.
  - After bit 0: POST: C_int = MMM(X, 1).
  - Then DONE.
- DONE:
  - eoc=1, busy=0, C=C_int.
  - Holds indefinitely, including when en=1, until rst. A new computation requires rst followed by en.
- Latency:
  - With K = 3 + WIDTH + popcount(E), eoc rises exactly K*(WIDTH+1) en-active cycles after the IDLE latch edge.
  - On the error path eoc and err rise 1 cycle after the latch edge.
- Boundary values:
  - E=0 gives C=1.
  - M=0 gives C=0 for E>0.
  - M=P-1 with odd E gives C=P-1.
- Const is not checked. A wrong Const produces a wrong C with err=0.
- busy=1 from the latch edge until DONE. busy and eoc are never high together.

Test Plan:
- WIDTH=8, P=13, Const=3, M=5, E=3, en held high -> eoc rises 117 cycles after the latch edge, C=8, err=0; C and eoc stay stable for 50 further cycles.
- P=13, Const=3, M=5, E=0 -> C=1, eoc after 99 cycles.
- P=251, Const=25, M=250, E=0xFF -> C=250, eoc after 171 cycles.
- Error path: P=12 (even) -> eoc=1, err=1, C=0 one cycle after the latch. Separately, P=13, M=13 -> same error response.
- Rerun of the first scenario with en dropped for 20 cycles at cycle 40 and inputs randomised after the latch -> C=8, eoc at 137 cycles, busy held high throughout the pause.
- rst pulsed at cycle 60 of the first scenario -> next edge: eoc=0, busy=0, C=0, state IDLE. A subsequent en with P=13, Const=3, M=5, E=3 -> C=8 after 117 cycles.
